sift_octave_ctrl: RTL and testbench
===================================

# sift_octave_ctrl

Frame-level sequencer and keypoint formatter for an N-octave SIFT feature pipeline. It replaces the fixed two-octave control, with its hard-coded address offsets, by a parametrised controller. Per frame it resets and runs the feature core once per octave and translates each octave-local keypoint address into full-resolution (x, y) coordinates. Keypoints are buffered in a ready/valid FIFO for the descriptor stage.

## Interface
Parameters:
- N_OCT, 3, octaves processed per frame (1..2^OCT_W)
- OCT_W, 2, width of octave index
- IMG_W_LOG2, 9, log2 of octave-0 image width
- IMG_H_LOG2, 8, log2 of octave-0 image height
- ADDR_W, 18, width of raw core address
- KP_LAT, 20, core pipeline offset subtracted from raw address (same for every octave)
- RST_CYC, 4, cycles core reset is held low before each octave (>=1)
- FIFO_DEPTH, 16, keypoint FIFO entries (power of 2)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse: new image is available, start/restart the frame
- core_rst_n  out  1  active-low reset to the feature core
- oct_idx  out  OCT_W  octave currently running
- oct_done  in  1  one-cycle pulse from core: current octave finished
- kp_in  in  1  core keypoint strobe
- kp_raw_addr  in  ADDR_W  core address counter sampled with kp_in
- kp_valid  out  1  FIFO head valid
- kp_ready  in  1  consumer accepts head
- kp_x  out  IMG_W_LOG2  full-resolution column
- kp_y  out  IMG_H_LOG2  full-resolution row
- kp_oct  out  OCT_W  octave of keypoint
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse: last octave finished
- kp_ovf  out  1  sticky: a keypoint was dropped on FIFO full
- kp_count  out  16  keypoints accepted into FIFO this frame (saturates at 0xFFFF)

## Operation
- States: IDLE, ORST, RUN, DONE.
- IDLE: core_rst_n=0, busy=0. frame_start -> ORST, oct_idx=0, FIFO flushed, kp_ovf=0, kp_count=0.
- ORST: core_rst_n=0 for RST_CYC cycles (down-counter), then -> RUN.
- RUN: core_rst_n=1. On oct_done:
  - if oct_idx<N_OCT-1 -> ORST with oct_idx+1;
  - else -> DONE.
- DONE: frame_done=1 for one cycle -> IDLE. The FIFO is not flushed, so the consumer may still drain it.
- frame_start in ORST/RUN/DONE: abort the frame and act exactly as frame_start in IDLE (restart at octave 0, flush). It takes priority over a same-cycle oct_done.
- oct_done outside RUN is ignored.
- Keypoint capture only when state==RUN and kp_in=1; kp_in in any other state is ignored.
- Translation for octave o:
  - idx = kp_raw_addr - KP_LAT (ADDR_W bits);
  - row = idx >> (IMG_W_LOG2-o);
  - col = idx & ((1<<(IMG_W_LOG2-o))-1);
  - kp_x = col<<o, kp_y = row<<o, both truncated to port width.
- Discard rules (no FIFO write, no count):
  - kp_raw_addr < KP_LAT;
  - row >= 2^(IMG_H_LOG2-o).
- FIFO behaviour:
  - Full with no pop: keypoint dropped, kp_ovf set, held until next frame_start.
  - Full with simultaneous pop: push accepted.
  - Empty: kp_valid=0. Head outputs are don't-care when kp_valid=0.
- kp_count increments on each accepted push and saturates at 0xFFFF.

## Timing
- Reset values: core_rst_n=0, oct_idx=0, kp_valid=0, kp_x=0, kp_y=0, kp_oct=0, busy=0, frame_done=0, kp_ovf=0, kp_count=0; state IDLE.
- frame_start at cycle t: busy=1 and core_rst_n=0 from t+1; core_rst_n=1 from t+1+RST_CYC.
- oct_done at t (non-last): core_rst_n=0 from t+1 for RST_CYC cycles, oct_idx updates at t+1.
- Last oct_done at t: frame_done=1 at t+1, busy=0 at t+2.
- Capture pipeline: kp_in at t is registered at t+1 (translation) and written at t+2; kp_valid is high at t+2 if the FIFO was empty.
- A keypoint whose kp_in falls in the cycle of oct_done is captured with the old oct_idx.
- Pop when kp_valid & kp_ready; next head is presented the following cycle. Full throughput: one push and one pop per cycle.

## Test plan
- IMG_W_LOG2=4, IMG_H_LOG2=4, KP_LAT=5, N_OCT=3, RST_CYC=4. frame_start, then oct_done three times -> core_rst_n low exactly 4 cycles before each octave, oct_idx 0,1,2, frame_done single pulse, busy=0 after.
- Octave 1, kp_raw_addr=24 -> kp_x=6, kp_y=4, kp_oct=1, kp_valid 2 cycles after kp_in. Octave 0, addr=5 -> (0,0,0).
- kp_raw_addr=3 -> discarded, kp_count unchanged. Octave 2, addr=5+16 (row 4 >= 4) -> discarded.
- kp_ready=0, 17 keypoints with FIFO_DEPTH=16 -> 16 stored, kp_ovf=1, kp_count=16. Then pop and push in the same cycle while full -> accepted, kp_count=17.
- frame_start mid-octave 1 with 3 entries buffered -> FIFO empty, oct_idx=0, kp_ovf and kp_count cleared, core_rst_n low 4 cycles. Same-cycle oct_done is ignored.
- Assert rst mid-RUN -> all outputs return to reset values immediately and the block stays in IDLE until frame_start.

Source files
------------

// File: rtl/sift_octave_ctrl.sv
// Frame sequencer for an N-octave SIFT core: resets and runs the core once per octave,
// maps octave-local keypoint addresses to full-resolution (x, y) and buffers them in a FIFO.
module sift_octave_ctrl #(
    parameter int N_OCT      = 3,
    parameter int OCT_W      = 2,
    parameter int IMG_W_LOG2 = 9,
    parameter int IMG_H_LOG2 = 8,
    parameter int ADDR_W     = 18,
    parameter int KP_LAT     = 20,
    parameter int RST_CYC    = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    output logic                  core_rst_n,
    output logic [OCT_W-1:0]      oct_idx,
    input  logic                  oct_done,
    input  logic                  kp_in,
    input  logic [ADDR_W-1:0]     kp_raw_addr,
    output logic                  kp_valid,
    input  logic                  kp_ready,
    output logic [IMG_W_LOG2-1:0] kp_x,
    output logic [IMG_H_LOG2-1:0] kp_y,
    output logic [OCT_W-1:0]      kp_oct,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  kp_ovf,
    output logic [15:0]           kp_count
);
    localparam int CNT_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW1   = PTR_W + 1;
    localparam int ENT_W = OCT_W + IMG_H_LOG2 + IMG_W_LOG2;

    localparam logic [CNT_W-1:0]  RST_LOAD = CNT_W'(RST_CYC - 1);
    localparam logic [OCT_W-1:0]  LAST_OCT = OCT_W'(N_OCT - 1);
    localparam logic [ADDR_W-1:0] LAT_A    = ADDR_W'(KP_LAT);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
    localparam logic [PTR_W:0]    DEPTH_P  = PW1'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ORST, RUN, DONE} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OCT_W-1:0]    oct_q, oct_d;

    logic                    vld_p1_q, vld_p1_d;
    logic [IMG_W_LOG2-1:0]   x_p1_q, x_c;
    logic [IMG_H_LOG2-1:0]   y_p1_q, y_c;
    logic [OCT_W-1:0]        oct_p1_q;
    logic                    keep_c;

    logic [ENT_W-1:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fill;
    logic                    ovf_q, ovf_d;
    logic [15:0]             count_q, count_d;
    logic                    empty, full, push, pop, drop;
    logic [ENT_W-1:0]        head;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Octave o works on a (W>>o) x (H>>o) image; scale back by 2^o, drop out-of-frame rows.
    function automatic void xlate(
        input  logic [ADDR_W-1:0]     addr,
        input  logic [OCT_W-1:0]      oct,
        output logic [IMG_W_LOG2-1:0] x,
        output logic [IMG_H_LOG2-1:0] y,
        output logic                  keep
    );
        logic [ADDR_W-1:0] idx, row, col, row_lim;
        int                sh_w, sh_h;
        sh_w    = IMG_W_LOG2 - int'(oct);
        sh_h    = IMG_H_LOG2 - int'(oct);
        idx     = addr - LAT_A;
        row     = idx >> sh_w;
        col     = idx & ((ONE_A << sh_w) - ONE_A);
        row_lim = ONE_A << sh_h;
        x       = IMG_W_LOG2'(col << oct);
        y       = IMG_H_LOG2'(row << oct);
        keep    = (addr >= LAT_A) && (row < row_lim);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        oct_d   = oct_q;
        if (frame_start) begin
            state_d = ORST;
            cnt_d   = RST_LOAD;
            oct_d   = '0;
        end else begin
            case (state_q)
                IDLE: ;
                ORST: begin
                    if (cnt_q == '0) state_d = RUN;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                RUN: begin
                    if (oct_done) begin
                        if (oct_q < LAST_OCT) begin
                            state_d = ORST;
                            cnt_d   = RST_LOAD;
                            oct_d   = oct_q + OCT_W'(1);
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign core_rst_n = (state_q == RUN);
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
    assign oct_idx    = oct_q;

    // p0 -> p1: translate and qualify the keypoint in the capture cycle
    always_comb begin
        x_c    = '0;
        y_c    = '0;
        keep_c = 1'b0;
        xlate(kp_raw_addr, oct_q, x_c, y_c, keep_c);
        vld_p1_d = (state_q == RUN) && kp_in && keep_c && !frame_start;
    end

    // p1 -> FIFO: write the registered keypoint; a flush overrides any same-cycle push
    always_comb begin
        fill  = wr_ptr_q - rd_ptr_q;
        empty = (fill == '0);
        full  = (fill == DEPTH_P);
        pop   = !empty && kp_ready;
        push  = vld_p1_q && (!full || pop);
        drop  = vld_p1_q && full && !pop;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        count_d  = count_q;
        if (frame_start) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW1'(1);
                count_d  = sat_inc16(count_q);
            end
            if (pop)  rd_ptr_d = rd_ptr_q + PW1'(1);
            if (drop) ovf_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            oct_q    <= '0;
            vld_p1_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            oct_q    <= oct_d;
            vld_p1_q <= vld_p1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        x_p1_q   <= x_c;
        y_p1_q   <= y_c;
        oct_p1_q <= oct_q;
        if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {oct_p1_q, y_p1_q, x_p1_q};
    end

    assign head     = fifo_mem[rd_ptr_q[PTR_W-1:0]];
    assign kp_valid = !empty;
    assign {kp_oct, kp_y, kp_x} = kp_valid ? head : '0;
    assign kp_ovf   = ovf_q;
    assign kp_count = count_q;

endmodule

// File: tb/tb_sift_octave_ctrl.sv
// Directed + randomized bench for sift_octave_ctrl against a queue-based keypoint model.
module tb_sift_octave_ctrl;
    localparam int N_OCT   = 3;
    localparam int OCT_W   = 2;
    localparam int IW      = 4;
    localparam int IH      = 4;
    localparam int ADDR_W  = 18;
    localparam int KP_LAT  = 5;
    localparam int RST_CYC = 4;
    localparam int DEPTH   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              frame_start = 1'b0;
    logic              oct_done = 1'b0;
    logic              kp_in = 1'b0;
    logic              kp_ready = 1'b0;
    logic [ADDR_W-1:0] kp_raw_addr = '0;
    logic              core_rst_n, kp_valid, busy, frame_done, kp_ovf;
    logic [OCT_W-1:0]  oct_idx, kp_oct;
    logic [IW-1:0]     kp_x;
    logic [IH-1:0]     kp_y;
    logic [15:0]       kp_count;

    always #5 clk = ~clk;

    sift_octave_ctrl #(
        .N_OCT(N_OCT), .OCT_W(OCT_W), .IMG_W_LOG2(IW), .IMG_H_LOG2(IH),
        .ADDR_W(ADDR_W), .KP_LAT(KP_LAT), .RST_CYC(RST_CYC), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .core_rst_n(core_rst_n),
        .oct_idx(oct_idx), .oct_done(oct_done), .kp_in(kp_in), .kp_raw_addr(kp_raw_addr),
        .kp_valid(kp_valid), .kp_ready(kp_ready), .kp_x(kp_x), .kp_y(kp_y),
        .kp_oct(kp_oct), .busy(busy), .frame_done(frame_done), .kp_ovf(kp_ovf),
        .kp_count(kp_count)
    );

    typedef struct { int x; int y; int o; } kp_t;
    kp_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  exp_count = 0;
    int  exp_ovf = 0;
    int  cur_oct = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Octave o sees a 2^(IW-o) x 2^(IH-o) image in raster order; scale coordinates by 2^o.
    function automatic bit ref_xlate(input int addr, input int o, output kp_t k);
        int idx, cols, rows;
        k = '{0, 0, 0};
        if (addr < KP_LAT) return 1'b0;
        idx  = addr - KP_LAT;
        cols = 2 ** (IW - o);
        rows = 2 ** (IH - o);
        if (idx / cols >= rows) return 1'b0;
        k.x = (idx % cols) * (2 ** o);
        k.y = (idx / cols) * (2 ** o);
        k.o = o;
        return 1'b1;
    endfunction

    task automatic model_kp(input int addr);
        kp_t k;
        if (ref_xlate(addr, cur_oct, k)) begin
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back(k);
                exp_count++;
            end else begin
                exp_ovf = 1;
            end
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_count = 0;
        exp_ovf   = 0;
        cur_oct   = 0;
    endtask

    task automatic send_kp(input int addr);
        kp_in       = 1'b1;
        kp_raw_addr = ADDR_W'(addr);
        model_kp(addr);
        tick();
        kp_in = 1'b0;
    endtask

    task automatic random_kps(input int n);
        int span;
        span = KP_LAT + 2 ** (IW + IH - 2 * cur_oct) + 8;
        for (int i = 0; i < n; i++) send_kp(int'($urandom_range(span, 0)));
    endtask

    // Starts one cycle after the edge that launched the reset phase; keypoints offered here are ignored.
    task automatic chk_orst(input string tag);
        for (int i = 0; i < RST_CYC; i++) begin
            chk($sformatf("%s_rstlo%0d", tag, i), 32'(core_rst_n), 0);
            chk($sformatf("%s_busy%0d", tag, i), 32'(busy), 1);
            kp_in       = 1'b1;
            kp_raw_addr = ADDR_W'(KP_LAT);
            tick();
        end
        kp_in = 1'b0;
        chk({tag, "_rsthi"}, 32'(core_rst_n), 1);
        chk({tag, "_oct"}, 32'(oct_idx), cur_oct);
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        model_clear();
    endtask

    task automatic next_oct(input string tag, input int kp_addr);
        oct_done = 1'b1;
        if (kp_addr >= 0) begin
            kp_in       = 1'b1;
            kp_raw_addr = ADDR_W'(kp_addr);
            model_kp(kp_addr);
        end
        tick();
        oct_done = 1'b0;
        kp_in    = 1'b0;
        cur_oct++;
        chk_orst(tag);
    endtask

    task automatic drain(input string tag);
        kp_t k;
        kp_ready = 1'b1;
        while (exp_q.size() > 0) begin
            k = exp_q.pop_front();
            chk({tag, "_vld"}, 32'(kp_valid), 1);
            chk({tag, "_x"}, 32'(kp_x), k.x);
            chk({tag, "_y"}, 32'(kp_y), k.y);
            chk({tag, "_o"}, 32'(kp_oct), k.o);
            tick();
        end
        kp_ready = 1'b0;
        chk({tag, "_empty"}, 32'(kp_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        kp_t k;
        int  a;

        // Reset values
        repeat (2) tick();
        chk("rst_core_rst_n", 32'(core_rst_n), 0);
        chk("rst_oct_idx", 32'(oct_idx), 0);
        chk("rst_kp_valid", 32'(kp_valid), 0);
        chk("rst_kp_x", 32'(kp_x), 0);
        chk("rst_kp_y", 32'(kp_y), 0);
        chk("rst_kp_oct", 32'(kp_oct), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_kp_ovf", 32'(kp_ovf), 0);
        chk("rst_kp_count", 32'(kp_count), 0);
        rst = 1'b1;
        repeat (2) tick();

        // oct_done and kp_in while idle do nothing
        oct_done = 1'b1; kp_in = 1'b1; kp_raw_addr = ADDR_W'(KP_LAT + 3);
        tick();
        oct_done = 1'b0; kp_in = 1'b0;
        repeat (2) tick();
        chk("idle_oct", 32'(oct_idx), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_vld", 32'(kp_valid), 0);
        chk("idle_count", 32'(kp_count), 0);

        // Frame A, octave 0
        start_frame();
        chk_orst("a0");
        send_kp(5);
        chk("a0_lat1", 32'(kp_valid), 0);
        tick();
        chk("a0_lat2", 32'(kp_valid), 1);
        chk("a0_x", 32'(kp_x), 0);
        chk("a0_y", 32'(kp_y), 0);
        chk("a0_o", 32'(kp_oct), 0);
        send_kp(3);
        repeat (2) tick();
        chk("a0_disc_count", 32'(kp_count), 1);
        random_kps(4);
        repeat (2) tick();
        chk("a0_count", 32'(kp_count), exp_count);
        drain("a0");

        // Octave 1
        next_oct("a1", -1);
        send_kp(24);
        chk("a1_lat1", 32'(kp_valid), 0);
        tick();
        chk("a1_lat2", 32'(kp_valid), 1);
        chk("a1_x", 32'(kp_x), 6);
        chk("a1_y", 32'(kp_y), 4);
        chk("a1_o", 32'(kp_oct), 1);
        random_kps(4);
        repeat (2) tick();
        chk("a1_count", 32'(kp_count), exp_count);
        drain("a1");

        // Octave 2, entered with a keypoint that still belongs to octave 1
        next_oct("a2", 24);
        a = exp_count;
        send_kp(KP_LAT + 16);
        repeat (2) tick();
        chk("a2_disc_count", 32'(kp_count), a);
        random_kps(4);
        oct_done = 1'b1;
        tick();
        oct_done = 1'b0;
        chk("a_fd1", 32'(frame_done), 1);
        chk("a_busy1", 32'(busy), 1);
        tick();
        chk("a_fd2", 32'(frame_done), 0);
        chk("a_busy2", 32'(busy), 0);
        chk("a_core_rst", 32'(core_rst_n), 0);
        tick();
        chk("a_fd3", 32'(frame_done), 0);
        chk("a_count", 32'(kp_count), exp_count);
        drain("a_post");

        // Frame B: overflow, then pop+push while full
        start_frame();
        chk_orst("b0");
        for (int i = 0; i < DEPTH + 1; i++) send_kp(KP_LAT + int'($urandom_range(255, 0)));
        repeat (2) tick();
        chk("b_ovf", 32'(kp_ovf), 1);
        chk("b_ovf_model", 32'(kp_ovf), exp_ovf);
        chk("b_count16", 32'(kp_count), DEPTH);
        chk("b_vld", 32'(kp_valid), 1);
        a = KP_LAT + int'($urandom_range(255, 0));
        kp_in = 1'b1; kp_raw_addr = ADDR_W'(a);
        tick();
        kp_in = 1'b0;
        kp_ready = 1'b1;
        k = exp_q.pop_front();
        chk("b_pp_x", 32'(kp_x), k.x);
        chk("b_pp_y", 32'(kp_y), k.y);
        tick();
        kp_ready = 1'b0;
        if (ref_xlate(a, cur_oct, k)) begin
            exp_q.push_back(k);
            exp_count++;
        end
        chk("b_count17", 32'(kp_count), DEPTH + 1);
        chk("b_ovf_held", 32'(kp_ovf), 1);
        drain("b_full");

        // Abort mid-octave 1 with buffered entries; same-cycle oct_done must lose
        next_oct("b1", -1);
        for (int i = 0; i < 3; i++) send_kp(KP_LAT + int'($urandom_range(63, 0)));
        repeat (2) tick();
        chk("c_pre_vld", 32'(kp_valid), 1);
        chk("c_pre_count", 32'(kp_count), exp_count);
        frame_start = 1'b1; oct_done = 1'b1;
        tick();
        frame_start = 1'b0; oct_done = 1'b0;
        model_clear();
        chk("c_vld", 32'(kp_valid), 0);
        chk("c_oct", 32'(oct_idx), 0);
        chk("c_count", 32'(kp_count), 0);
        chk("c_ovf", 32'(kp_ovf), 0);
        chk_orst("c0");

        // Asynchronous reset mid-RUN
        send_kp(KP_LAT + 7);
        tick();
        chk("d_pre_vld", 32'(kp_valid), 1);
        #2 rst = 1'b0;
        #1;
        chk("d_core_rst_n", 32'(core_rst_n), 0);
        chk("d_oct", 32'(oct_idx), 0);
        chk("d_vld", 32'(kp_valid), 0);
        chk("d_x", 32'(kp_x), 0);
        chk("d_y", 32'(kp_y), 0);
        chk("d_o", 32'(kp_oct), 0);
        chk("d_busy", 32'(busy), 0);
        chk("d_fd", 32'(frame_done), 0);
        chk("d_ovf", 32'(kp_ovf), 0);
        chk("d_count", 32'(kp_count), 0);
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        repeat (RST_CYC + 3) tick();
        chk("d_idle_busy", 32'(busy), 0);
        chk("d_idle_core", 32'(core_rst_n), 0);
        start_frame();
        chk_orst("e0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
